// File: rtl/external_bus_arbiter.sv
// rtl/external_bus_arbiter.sv - two-master round-robin arbiter and sequencer for the 16-bit external bus
//
// Purpose: grants the shared peripheral bus to one of two masters at a time.
// It drives a single registered transaction onto the bus, then returns the
// captured read data and a one-cycle done pulse to the owning master.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a transaction is aborted after TIMEOUT_CYCLES bus cycles
//   without acknowledge. The owner then gets done and error together, with
//   zero read data. When undefined, the bus waits for acknowledge forever
//   and mN_error stays 0.
//
// Ports:
//   clk_clk, reset_reset_n          clock, asynchronous active-low reset
//   mN_request/address/byte_enable/rw/write_data   master N request and fields
//   mN_grant, mN_done, mN_error, mN_read_data      master N status and return data
//   address, bus_enable, byte_enable, rw, write_data   registered shared bus
//   acknowledge, read_data           peripheral response

module external_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        m0_request,
  input  logic [18:0] m0_address,
  input  logic [1:0]  m0_byte_enable,
  input  logic        m0_rw,
  input  logic [15:0] m0_write_data,
  output logic        m0_grant,
  output logic        m0_done,
  output logic        m0_error,
  output logic [15:0] m0_read_data,
  input  logic        m1_request,
  input  logic [18:0] m1_address,
  input  logic [1:0]  m1_byte_enable,
  input  logic        m1_rw,
  input  logic [15:0] m1_write_data,
  output logic        m1_grant,
  output logic        m1_done,
  output logic        m1_error,
  output logic [15:0] m1_read_data,
  output logic [18:0] address,
  output logic        bus_enable,
  output logic [1:0]  byte_enable,
  output logic        rw,
  output logic [15:0] write_data,
  input  logic        acknowledge,
  input  logic [15:0] read_data
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUS  = 1'b1;

  // The timeout count is only 8 bits wide, so anything outside 1..255 is unusable.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("external_bus_arbiter: TIMEOUT_CYCLES must be 1..255");
  end

  logic [0:0] state;
  logic       owner;      // 0 = master 0, 1 = master 1
  logic       last;       // master served most recently
  logic       winner;
  logic       timed_out;
  logic       finish;

  // When both masters request, the one not served last wins.
  assign winner = (m0_request && m1_request) ? ~last : m1_request;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count;

  // An acknowledge on the final cycle takes priority over the abort.
  assign timed_out = (state == BUS) && !acknowledge && (count == LAST_COUNT);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      count <= 8'd0;
    end else if (state == IDLE) begin
      count <= 8'd0;
    end else if (!acknowledge && !timed_out) begin
      count <= count + 8'd1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  assign finish = (state == BUS) && (acknowledge || timed_out);

  // Grants follow the registered strobe, so they drop with it on reset and completion.
  assign m0_grant = bus_enable & ~owner;
  assign m1_grant = bus_enable & owner;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last         <= 1'b1;
      address      <= 19'd0;
      bus_enable   <= 1'b0;
      byte_enable  <= 2'd0;
      rw           <= 1'b0;
      write_data   <= 16'd0;
      m0_done      <= 1'b0;
      m1_done      <= 1'b0;
      m0_error     <= 1'b0;
      m1_error     <= 1'b0;
      m0_read_data <= 16'd0;
      m1_read_data <= 16'd0;
    end else begin
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      m0_error <= 1'b0;
      m1_error <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_request || m1_request) begin
            owner       <= winner;
            address     <= winner ? m1_address     : m0_address;
            byte_enable <= winner ? m1_byte_enable : m0_byte_enable;
            rw          <= winner ? m1_rw          : m0_rw;
            write_data  <= winner ? m1_write_data  : m0_write_data;
            bus_enable  <= 1'b1;
            state       <= BUS;
          end
        end
        BUS: begin
          if (finish) begin
            bus_enable <= 1'b0;
            last       <= owner;
            state      <= IDLE;
            // Writes also capture read_data; an aborted transaction returns zero.
            if (owner) begin
              m1_done      <= 1'b1;
              m1_error     <= timed_out;
              m1_read_data <= acknowledge ? read_data : 16'h0000;
            end else begin
              m0_done      <= 1'b1;
              m0_error     <= timed_out;
              m0_read_data <= acknowledge ? read_data : 16'h0000;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_external_bus_arbiter.sv
// tb/tb_external_bus_arbiter.sv - self-checking bench for external_bus_arbiter

module tb_external_bus_arbiter;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        m0_request, m1_request;
  logic [18:0] m0_address, m1_address;
  logic [1:0]  m0_byte_enable, m1_byte_enable;
  logic        m0_rw, m1_rw;
  logic [15:0] m0_write_data, m1_write_data;
  logic        m0_grant, m1_grant, m0_done, m1_done, m0_error, m1_error;
  logic [15:0] m0_read_data, m1_read_data;
  logic [18:0] address;
  logic        bus_enable, rw;
  logic [1:0]  byte_enable;
  logic [15:0] write_data;
  logic        acknowledge;
  logic [15:0] read_data;

  logic        ack_en;
  logic [15:0] perip_data;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        m;
    logic [15:0] rd;
    logic        err;
  } exp_t;
  exp_t sb[$];

  // Snapshot of the bus on the first cycle bus_enable is seen high.
  logic        snap_valid;
  logic [18:0] snap_addr;
  logic [1:0]  snap_be;
  logic        snap_rw;
  logic [15:0] snap_wd;
  logic [1:0]  snap_grant;

  always #5 clk_clk = ~clk_clk;

  assign acknowledge = bus_enable & ack_en;
  assign read_data   = perip_data;

  external_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m0_request(m0_request), .m0_address(m0_address), .m0_byte_enable(m0_byte_enable),
    .m0_rw(m0_rw), .m0_write_data(m0_write_data), .m0_grant(m0_grant), .m0_done(m0_done),
    .m0_error(m0_error), .m0_read_data(m0_read_data),
    .m1_request(m1_request), .m1_address(m1_address), .m1_byte_enable(m1_byte_enable),
    .m1_rw(m1_rw), .m1_write_data(m1_write_data), .m1_grant(m1_grant), .m1_done(m1_done),
    .m1_error(m1_error), .m1_read_data(m1_read_data),
    .address(address), .bus_enable(bus_enable), .byte_enable(byte_enable), .rw(rw),
    .write_data(write_data), .acknowledge(acknowledge), .read_data(read_data)
  );

  task automatic drive(input logic m, input logic req, input logic [18:0] a,
                       input logic [1:0] be, input logic r, input logic [15:0] wd);
    if (m) begin
      m1_request = req; m1_address = a; m1_byte_enable = be; m1_rw = r; m1_write_data = wd;
    end else begin
      m0_request = req; m0_address = a; m0_byte_enable = be; m0_rw = r; m0_write_data = wd;
    end
  endtask

  // Waits (bounded) for a done pulse; reports latency in samples and bus_enable-high cycles.
  task automatic wait_done(output logic got, output logic m, output int hi, output int lat);
    got = 1'b0; m = 1'b0; hi = 0; lat = 0; snap_valid = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk_clk);
      lat++;
      if (bus_enable) begin
        hi++;
        if (!snap_valid) begin
          snap_valid = 1'b1; snap_addr = address; snap_be = byte_enable;
          snap_rw = rw; snap_wd = write_data; snap_grant = {m1_grant, m0_grant};
        end
      end
      if (m0_done || m1_done) begin
        got = 1'b1; m = m1_done;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL done_wait: no done within 64 cycles");
    end
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    m0_request = 0; m1_request = 0;
    drive(0, 0, 19'd0, 2'd0, 0, 16'd0);
    drive(1, 0, 19'd0, 2'd0, 0, 16'd0);
    ack_en = 1'b1; perip_data = 16'd0;
    repeat (2) @(negedge clk_clk);
    total++;
    if ({bus_enable, address, byte_enable, rw, write_data} !== 39'd0) begin
      bad++; $display("FAIL reset_bus: got %h required 0", {bus_enable, address, byte_enable, rw, write_data});
    end
    total++;
    if ({m0_grant, m1_grant, m0_done, m1_done, m0_error, m1_error} !== 6'd0) begin
      bad++; $display("FAIL reset_status: got %b required 000000", {m0_grant, m1_grant, m0_done, m1_done, m0_error, m1_error});
    end
    total++;
    if ({m0_read_data, m1_read_data} !== 32'd0) begin
      bad++; $display("FAIL reset_rdata: got %h required 0", {m0_read_data, m1_read_data});
    end
    reset_reset_n = 1'b1;
    @(negedge clk_clk);
  endtask

  task automatic test_single_write();
    logic got, m; int hi, lat; exp_t e;
    perip_data = 16'h0F0F; ack_en = 1'b1;
    drive(0, 1, 19'h20000, 2'b11, 0, 16'hA5A5);
    sb.push_back('{1'b0, 16'h0F0F, 1'b0});
    wait_done(got, m, hi, lat);
    drive(0, 0, 19'h20000, 2'b11, 0, 16'hA5A5);
    if (got) begin
      e = sb.pop_front();
      total++;
      if ({snap_addr, snap_be, snap_rw, snap_wd} !== {19'h20000, 2'b11, 1'b0, 16'hA5A5}) begin
        bad++; $display("FAIL write_fields: got %h %b %b %h required 20000 11 0 a5a5", snap_addr, snap_be, snap_rw, snap_wd);
      end
      total++;
      if (snap_grant !== 2'b01) begin
        bad++; $display("FAIL write_grant: got %b required 01", snap_grant);
      end
      total++;
      if (hi !== 1 || lat !== 2) begin
        bad++; $display("FAIL write_timing: got hi=%0d lat=%0d required hi=1 lat=2", hi, lat);
      end
      total++;
      if (m !== e.m || m0_error !== e.err || bus_enable !== 1'b0) begin
        bad++; $display("FAIL write_done: got m=%b err=%b be=%b required m=%b err=%b be=0", m, m0_error, bus_enable, e.m, e.err);
      end
      total++;
      if (m0_read_data !== e.rd) begin
        bad++; $display("FAIL write_rdata: got %h required %h", m0_read_data, e.rd);
      end
    end
    @(negedge clk_clk);
    total++;
    if (m0_done !== 1'b0 || bus_enable !== 1'b0) begin
      bad++; $display("FAIL write_pulse: got done=%b be=%b required 0 0", m0_done, bus_enable);
    end
  endtask

  task automatic test_read();
    logic got, m; int hi, lat; exp_t e;
    perip_data = 16'h1234; ack_en = 1'b1;
    drive(1, 1, 19'h00123, 2'b01, 1, 16'h5555);
    sb.push_back('{1'b1, 16'h1234, 1'b0});
    wait_done(got, m, hi, lat);
    drive(1, 0, 19'h00123, 2'b01, 1, 16'h5555);
    if (got) begin
      e = sb.pop_front();
      total++;
      if ({snap_addr, snap_be, snap_rw, snap_grant} !== {19'h00123, 2'b01, 1'b1, 2'b10}) begin
        bad++; $display("FAIL read_fields: got %h %b %b %b required 00123 01 1 10", snap_addr, snap_be, snap_rw, snap_grant);
      end
      total++;
      if (m !== e.m || m1_read_data !== e.rd || m1_error !== e.err) begin
        bad++; $display("FAIL read_done: got m=%b rd=%h err=%b required m=%b rd=%h err=%b", m, m1_read_data, m1_error, e.m, e.rd, e.err);
      end
      total++;
      if (m0_read_data !== 16'h0F0F) begin
        bad++; $display("FAIL read_other: got %h required 0f0f", m0_read_data);
      end
    end
    @(negedge clk_clk);
    total++;
    if (address !== 19'h00123 || bus_enable !== 1'b0) begin
      bad++; $display("FAIL idle_hold: got addr=%h be=%b required 00123 0", address, bus_enable);
    end
  endtask

  task automatic test_contention();
    logic got, m; int hi, lat; exp_t e;
    reset_reset_n = 1'b0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    ack_en = 1'b1; perip_data = 16'h1000;
    drive(0, 1, 19'h00010, 2'b11, 0, 16'h0101);
    drive(1, 1, 19'h00020, 2'b11, 0, 16'h0202);
    for (int k = 0; k < 4; k++) sb.push_back('{logic'(k[0]), 16'h1000 + 16'(k), 1'b0});
    for (int k = 0; k < 4; k++) begin
      wait_done(got, m, hi, lat);
      if (k == 3) begin
        drive(0, 0, 19'h00010, 2'b11, 0, 16'h0101);
        drive(1, 0, 19'h00020, 2'b11, 0, 16'h0202);
      end
      if (!got) break;
      e = sb.pop_front();
      total++;
      if (m !== e.m || (m ? m1_read_data : m0_read_data) !== e.rd) begin
        bad++; $display("FAIL contend_order[%0d]: got m=%b rd=%h required m=%b rd=%h", k, m, m ? m1_read_data : m0_read_data, e.m, e.rd);
      end
      total++;
      if ((m0_done & m1_done) !== 1'b0 || bus_enable !== 1'b0 || hi !== 1 || lat !== 2) begin
        bad++; $display("FAIL contend_gap[%0d]: got both=%b be=%b hi=%0d lat=%0d required 0 0 1 2", k, m0_done & m1_done, bus_enable, hi, lat);
      end
      perip_data = 16'h1000 + 16'(k + 1);
    end
    @(negedge clk_clk);
  endtask

  task automatic test_reset_mid_bus();
    logic got, m; int hi, lat; exp_t e;
    // Serve m0 first so that without a pointer reset m1 would win next.
    ack_en = 1'b1; perip_data = 16'h4242;
    drive(0, 1, 19'h00040, 2'b10, 0, 16'h4444);
    wait_done(got, m, hi, lat);
    drive(0, 0, 19'h00040, 2'b10, 0, 16'h4444);
    @(negedge clk_clk);
    ack_en = 1'b0;
    drive(0, 1, 19'h00050, 2'b10, 0, 16'h5050);
    repeat (3) @(negedge clk_clk);
    total++;
    if (bus_enable !== 1'b1 || m0_grant !== 1'b1) begin
      bad++; $display("FAIL stall_bus: got be=%b grant=%b required 1 1", bus_enable, m0_grant);
    end
    #2 reset_reset_n = 1'b0;
    #1;
    total++;
    if ({bus_enable, address, byte_enable, rw, write_data, m0_grant, m1_grant, m0_done, m1_done,
         m0_error, m1_error, m0_read_data, m1_read_data} !== 77'd0) begin
      bad++; $display("FAIL async_reset: got be=%b addr=%h grants=%b%b rd0=%h rd1=%h required all 0",
                      bus_enable, address, m0_grant, m1_grant, m0_read_data, m1_read_data);
    end
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    ack_en = 1'b1; perip_data = 16'h6666;
    drive(1, 1, 19'h00060, 2'b01, 1, 16'h6060);
    sb.push_back('{1'b0, 16'h6666, 1'b0});
    wait_done(got, m, hi, lat);
    drive(0, 0, 19'h00050, 2'b10, 0, 16'h5050);
    drive(1, 0, 19'h00060, 2'b01, 1, 16'h6060);
    if (got) begin
      e = sb.pop_front();
      total++;
      if (m !== e.m || m0_read_data !== e.rd || snap_addr !== 19'h00050) begin
        bad++; $display("FAIL restart_m0: got m=%b rd=%h addr=%h required m=%b rd=%h addr=00050", m, m0_read_data, snap_addr, e.m, e.rd);
      end
    end
    @(negedge clk_clk);
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic got, m; int hi, lat; exp_t e;
    ack_en = 1'b0; perip_data = 16'hBEEF;
    drive(0, 1, 19'h00070, 2'b11, 1, 16'h0000);
    sb.push_back('{1'b0, 16'h0000, 1'b1});
    wait_done(got, m, hi, lat);
    drive(0, 0, 19'h00070, 2'b11, 1, 16'h0000);
    if (got) begin
      e = sb.pop_front();
      total++;
      if (m !== e.m || m0_error !== e.err || m0_read_data !== e.rd) begin
        bad++; $display("FAIL timeout_done: got m=%b err=%b rd=%h required m=%b err=%b rd=%h", m, m0_error, m0_read_data, e.m, e.err, e.rd);
      end
      total++;
      if (hi !== 4) begin
        bad++; $display("FAIL timeout_len: got %0d required 4", hi);
      end
    end
    @(negedge clk_clk);
    total++;
    if (m0_done !== 1'b0 || m0_error !== 1'b0) begin
      bad++; $display("FAIL timeout_pulse: got done=%b err=%b required 0 0", m0_done, m0_error);
    end
  endtask

  task automatic test_timeout_boundary();
    logic got; int hi; exp_t e;
    ack_en = 1'b0; perip_data = 16'hC0DE;
    drive(0, 1, 19'h00080, 2'b11, 1, 16'h0000);
    sb.push_back('{1'b0, 16'hC0DE, 1'b0});
    got = 1'b0; hi = 0;
    for (int i = 0; i < 32 && !got; i++) begin
      @(negedge clk_clk);
      if (bus_enable) hi++;
      if (hi == 4) ack_en = 1'b1;
      if (m0_done || m1_done) got = 1'b1;
    end
    drive(0, 0, 19'h00080, 2'b11, 1, 16'h0000);
    if (!got) begin
      total++; bad++; $display("FAIL boundary_wait: no done within 32 cycles");
    end else begin
      e = sb.pop_front();
      total++;
      if (m0_done !== 1'b1 || m0_error !== e.err || m0_read_data !== e.rd || hi !== 4) begin
        bad++; $display("FAIL boundary_done: got done=%b err=%b rd=%h hi=%0d required 1 %b %h 4", m0_done, m0_error, m0_read_data, hi, e.err, e.rd);
      end
    end
    @(negedge clk_clk);
  endtask
`else
  task automatic test_no_timeout();
    logic got, m; int hi, lat; int dones; exp_t e;
    ack_en = 1'b0; perip_data = 16'h7777; dones = 0;
    drive(0, 1, 19'h00090, 2'b11, 1, 16'h0000);
    sb.push_back('{1'b0, 16'h7777, 1'b0});
    repeat (30) begin
      @(negedge clk_clk);
      if (m0_done || m1_done || m0_error) dones++;
    end
    total++;
    if (dones !== 0 || bus_enable !== 1'b1) begin
      bad++; $display("FAIL stall_hold: got dones=%0d be=%b required 0 1", dones, bus_enable);
    end
    ack_en = 1'b1;
    wait_done(got, m, hi, lat);
    drive(0, 0, 19'h00090, 2'b11, 1, 16'h0000);
    if (got) begin
      e = sb.pop_front();
      total++;
      if (m !== e.m || m0_error !== e.err || m0_read_data !== e.rd) begin
        bad++; $display("FAIL stall_done: got m=%b err=%b rd=%h required m=%b err=%b rd=%h", m, m0_error, m0_read_data, e.m, e.err, e.rd);
      end
    end
    @(negedge clk_clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_reset_mid_bus();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
    test_timeout_boundary();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/external_bus_arbiter.md
# external_bus_arbiter

Two-master arbiter and transaction sequencer for the 16-bit external bus that feeds the four-register peripheral. It samples requests from two independent masters and grants the bus round-robin. It drives the shared address, bus_enable, byte_enable, rw and write_data lines for one transaction at a time, then returns acknowledge-qualified read data and a done pulse to the owning master.

## Interface
- TIMEOUT_CYCLES, 16, maximum bus-owned cycles without acknowledge before abort; legal 1..255; used only with ARB_TIMEOUT_EN.
- clk_clk  in  1  single clock, all state on rising edge.
- reset_reset_n  in  1  reset, asynchronous, active-low.
- mN_request  in  1  master N (N=0,1) transaction request, level; hold with fields stable until mN_done.
- mN_address  in  19  master N address.
- mN_byte_enable  in  2  master N byte lanes.
- mN_rw  in  1  master N direction, 1=read, 0=write.
- mN_write_data  in  16  master N write data.
- mN_grant  out  1  master N currently owns the bus.
- mN_done  out  1  one-cycle completion pulse to master N.
- mN_error  out  1  one-cycle pulse with mN_done when the transaction timed out.
- mN_read_data  out  16  data captured at master N's last completion.
- address  out  19  shared bus address, registered.
- bus_enable  out  1  shared bus strobe, registered.
- byte_enable  out  2  shared bus byte lanes, registered.
- rw  out  1  shared bus direction, registered.
- write_data  out  16  shared bus write data, registered.
- acknowledge  in  1  peripheral acknowledge; may be combinational from bus_enable.
- read_data  in  16  peripheral read data, valid when acknowledge=1.

## Operation
- States: IDLE, BUS.
- IDLE: at an edge with any mN_request=1:
  - choose winner, latch its address/byte_enable/rw/write_data onto the bus outputs;
  - set bus_enable=1 and mN_grant=1 for the winner;
  - clear the cycle counter; go to BUS.
- IDLE with no request: outputs hold; bus_enable=0.
- Arbitration: single requester wins. If both request, the master not served last wins. The last-served pointer resets to 1, so master 0 wins the first contest.
- BUS: bus outputs held constant. At an edge with acknowledge=1:
  - capture read_data into the owner's mN_read_data (writes too);
  - pulse owner's mN_done; clear bus_enable and mN_grant; update the last-served pointer; go to IDLE.
- The request is sampled again at the next IDLE edge. A master leaving mN_request high after mN_done issues a new transaction (subject to arbitration).
- mN_read_data holds between completions. The non-owner's outputs are never disturbed.
- Bus output fields (address, byte_enable, rw, write_data) keep the last transaction's values while idle; only bus_enable qualifies them.
- Reset (any time, including mid-BUS): immediately state=IDLE, pointer=1, counter=0. Every output becomes 0: bus_enable, address, byte_enable, rw, write_data, grants, dones, errors, read_data registers. The aborted transaction is not reported.

## Timing
- Request high before edge E0 → bus_enable=1 after E0. With a combinational acknowledge: mN_done=1 and bus_enable=0 after E1, and mN_read_data is valid after E1.
- Minimum latency request→done: 2 edges. Back-to-back throughput: one transaction per 2 cycles.
- bus_enable is low for at least one full cycle between any two transactions, including the same master consecutively.
- mN_done, mN_error: exactly one cycle wide, never both masters in the same cycle.
- Grant is one-hot or zero; mN_grant equals bus_enable ANDed with ownership.

## Configuration
- ARB_TIMEOUT_EN defined:
  - an 8-bit counter increments each BUS cycle without acknowledge;
  - at the edge where counter==TIMEOUT_CYCLES-1 and acknowledge=0: abort, drop bus_enable, pulse owner's mN_done and mN_error, load mN_read_data=16'h0000, update pointer, go to IDLE;
  - bus_enable is therefore high exactly TIMEOUT_CYCLES cycles;
  - acknowledge on that same edge wins: normal completion, no error.
- ARB_TIMEOUT_EN undefined: no counter; BUS waits indefinitely for acknowledge; mN_error tied 0.

## Test plan
- Single write: m0 writes address=19'h20000, byte_enable=2'b11, data=16'hA5A5 with ack=bus_enable → bus_enable high exactly 1 cycle with those values; m0_done after 2 edges; m0_error=0.
- Read: peripheral returns 16'h1234 for m1 read → m1_read_data=16'h1234 after m1_done; m0_read_data unchanged.
- Contention: both request from reset and both hold → grants alternate m0,m1,m0,m1; bus_enable low 1 cycle between each.
- Reset mid-BUS: hold acknowledge=0, assert reset_reset_n=0 mid-cycle → all outputs 0 before next edge; after release, grant restarts with m0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack stuck 0) → bus_enable high 4 cycles; m0_done=m0_error=1 for one cycle; m0_read_data=16'h0000.
- Timeout boundary: ack asserted on 4th BUS cycle → normal done, error=0, read data captured.
